// File: rtl/mdu_ctrl_if.sv
// E-stage request bus into the multiply/divide controller and its HI/LO/busy view back.
// `cancel` exists only when MDU_CANCEL_EN is defined.
interface mdu_ctrl_if;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
`ifdef MDU_CANCEL_EN
        output cancel,
`endif
        output start, op, rs_data, rt_data,
        input  busy, hi, lo
    );

    modport slave (
`ifdef MDU_CANCEL_EN
        input  cancel,
`endif
        input  start, op, rs_data, rt_data,
        output busy, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// MIPS mult/div/mthi/mtlo sequencer owning HI/LO; optional abort via MDU_CANCEL_EN.
// Latency: mult MULT_CYCLES, div DIV_CYCLES busy cycles, commit on the last; mthi/mtlo 1 cycle.
// No backpressure: start is ignored while busy; the hazard unit must stall on start|busy.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] hi_n;
    logic [31:0] lo_n;
    logic        commit_en;
    logic        cancel_w;
    logic        accept;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] sdiv_b;
    logic [31:0] udiv_b;
    logic [31:0] sdiv_q;
    logic [31:0] sdiv_r;
    logic [31:0] udiv_q;
    logic [31:0] udiv_r;

`ifdef MDU_CANCEL_EN
    assign cancel_w = bus.cancel;
`else
    assign cancel_w = 1'b0;
`endif

    assign accept = bus.start && (state == ST_IDLE) && !cancel_w;

    assign prod_s = $signed({{32{bus.rs_data[31]}}, bus.rs_data})
                  * $signed({{32{bus.rt_data[31]}}, bus.rt_data});
    assign prod_u = {32'd0, bus.rs_data} * {32'd0, bus.rt_data};

    assign div_zero = (bus.rt_data == 32'd0);
    assign div_ovf  = (bus.rs_data == 32'h8000_0000) && (bus.rt_data == 32'hFFFF_FFFF);

    // Dividing by 1 instead of -1 in the overflow case yields exactly the
    // architected 0x80000000 / 0 pair; zero divisors are masked the same way
    // so the divider never sees 0 (its result is discarded anyway).
    assign sdiv_b = (div_zero || div_ovf) ? 32'd1 : bus.rt_data;
    assign udiv_b = div_zero ? 32'd1 : bus.rt_data;

    assign sdiv_q = $signed(bus.rs_data) / $signed(sdiv_b);
    assign sdiv_r = $signed(bus.rs_data) % $signed(sdiv_b);
    assign udiv_q = bus.rs_data / udiv_b;
    assign udiv_r = bus.rs_data % udiv_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            hi_n      <= 32'd0;
            lo_n      <= 32'd0;
            commit_en <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (accept) begin
                case (bus.op)
                    OP_MULT: begin
                        hi_n      <= prod_s[63:32];
                        lo_n      <= prod_s[31:0];
                        commit_en <= 1'b1;
                        cnt       <= MULT_LOAD;
                        state     <= ST_RUN;
                    end
                    OP_MULTU: begin
                        hi_n      <= prod_u[63:32];
                        lo_n      <= prod_u[31:0];
                        commit_en <= 1'b1;
                        cnt       <= MULT_LOAD;
                        state     <= ST_RUN;
                    end
                    OP_DIV: begin
                        hi_n      <= sdiv_r;
                        lo_n      <= sdiv_q;
                        commit_en <= !div_zero;
                        cnt       <= DIV_LOAD;
                        state     <= ST_RUN;
                    end
                    OP_DIVU: begin
                        hi_n      <= udiv_r;
                        lo_n      <= udiv_q;
                        commit_en <= !div_zero;
                        cnt       <= DIV_LOAD;
                        state     <= ST_RUN;
                    end
                    OP_MTHI: hi_q <= bus.rs_data;
                    OP_MTLO: lo_q <= bus.rs_data;
                    default: ;
                endcase
            end
        end else begin
            // Cancel wins even on the final cycle so HI/LO never see a flushed op.
            if (cancel_w) begin
                state <= ST_IDLE;
                cnt   <= 4'd0;
            end else if (cnt == 4'd0) begin
                state <= ST_IDLE;
                if (commit_en) begin
                    hi_q <= hi_n;
                    lo_q <= lo_n;
                end
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign bus.busy = (state == ST_RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table plus hand sequences for back-to-back, reset and cancel.
module tb_mdu_ctrl;

    logic clk;
    logic reset;

    mdu_ctrl_if bus();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        int          n;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    vec_t        vecs[15];
    exp_t        sb[$];
    exp_t        e;
    int          checks;
    int          failures;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Counts busy cycles from the current negedge; returns at the first idle one.
    task automatic wait_done(output int n, output bit stable);
        n = 0;
        stable = 1'b1;
        while (bus.busy === 1'b1 && n < 40) begin
            if (bus.hi !== m_hi || bus.lo !== m_lo) stable = 1'b0;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int  n;
        bit  stable;

        checks   = 0;
        failures = 0;
        vecs[0]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{3'd5, 32'h0000_0011, 32'd0,         0,  32'h0000_0011, 32'hFFFF_FFFD};
        vecs[4]  = '{3'd6, 32'h0000_0022, 32'd0,         0,  32'h0000_0011, 32'h0000_0022};
        vecs[5]  = '{3'd4, 32'd7,         32'd0,         10, 32'h0000_0011, 32'h0000_0022};
        vecs[6]  = '{3'd3, 32'd5,         32'd0,         10, 32'h0000_0011, 32'h0000_0022};
        vecs[7]  = '{3'd0, 32'h0000_1234, 32'd9,         0,  32'h0000_0011, 32'h0000_0022};
        vecs[8]  = '{3'd7, 32'h0000_1234, 32'd9,         0,  32'h0000_0011, 32'h0000_0022};
        vecs[9]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
        vecs[10] = '{3'd4, 32'd100,       32'd7,         10, 32'h0000_0002, 32'h0000_000E};
        vecs[11] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[12] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'h0000_0000, 32'h0000_0001};
        vecs[13] = '{3'd2, 32'h0001_0000, 32'h0001_0000, 5,  32'h0000_0001, 32'h0000_0000};
        vecs[14] = '{3'd4, 32'hFFFF_FFFF, 32'd16,        10, 32'h0000_000F, 32'h0FFF_FFFF};

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 3'd0;
        bus.rs_data = 32'd0;
        bus.rt_data = 32'd0;
`ifdef MDU_CANCEL_EN
        bus.cancel  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            bus.start   = 1'b1;
            bus.op      = vecs[i].op;
            bus.rs_data = vecs[i].a;
            bus.rt_data = vecs[i].b;
            sb.push_back('{vecs[i].n, vecs[i].hi, vecs[i].lo});
            @(negedge clk);
            bus.start = 1'b0;
            bus.op    = 3'd0;
            wait_done(n, stable);
            e = sb.pop_front();
            chk($sformatf("v%0d_busy_cycles", i), n, e.n);
            if (e.n > 0) chk($sformatf("v%0d_hold_while_busy", i), {31'd0, stable}, 32'd1);
            chk($sformatf("v%0d_hi", i), bus.hi, e.hi);
            chk($sformatf("v%0d_lo", i), bus.lo, e.lo);
            m_hi = e.hi;
            m_lo = e.lo;
            @(negedge clk);
        end

        // mthi, then mult the very next cycle, then a divu that must be ignored.
        bus.start   = 1'b1;
        bus.op      = 3'd5;
        bus.rs_data = 32'h0000_ABCD;
        @(negedge clk);
        chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
        chk("mthi_hi", bus.hi, 32'h0000_ABCD);
        m_hi        = 32'h0000_ABCD;
        bus.op      = 3'd1;
        bus.rs_data = 32'd2;
        bus.rt_data = 32'd3;
        sb.push_back('{5, 32'd0, 32'd6});
        @(negedge clk);
        chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
        bus.op      = 3'd4;
        bus.rs_data = 32'd100;
        bus.rt_data = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'd0;
        wait_done(n, stable);
        e = sb.pop_front();
        chk("b2b_busy_cycles", n + 1, e.n);
        chk("b2b_hold_while_busy", {31'd0, stable}, 32'd1);
        chk("b2b_hi", bus.hi, e.hi);
        chk("b2b_lo", bus.lo, e.lo);
        m_hi = e.hi;
        m_lo = e.lo;
        repeat (3) @(negedge clk);
        chk("ignored_start_busy", {31'd0, bus.busy}, 32'd0);
        chk("ignored_start_lo", bus.lo, 32'd6);

        // Reset in the third busy cycle of a div abandons it.
        bus.start   = 1'b1;
        bus.op      = 3'd3;
        bus.rs_data = 32'hFFFF_FFF9;
        bus.rt_data = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_run_busy_before", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_run_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_run_hi", bus.hi, 32'd0);
        chk("rst_run_lo", bus.lo, 32'd0);
        repeat (12) @(negedge clk);
        chk("rst_run_no_commit_lo", bus.lo, 32'd0);

`ifdef MDU_CANCEL_EN
        bus.start   = 1'b1;
        bus.op      = 3'd5;
        bus.rs_data = 32'h55;
        @(negedge clk);
        bus.op      = 3'd6;
        bus.rs_data = 32'h66;
        @(negedge clk);
        bus.op      = 3'd1;
        bus.rs_data = 32'd7;
        bus.rt_data = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'd0;
        @(negedge clk);
        chk("cancel_busy_before", {31'd0, bus.busy}, 32'd1);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        chk("cancel_busy", {31'd0, bus.busy}, 32'd0);
        chk("cancel_hi", bus.hi, 32'h55);
        chk("cancel_lo", bus.lo, 32'h66);
        repeat (8) @(negedge clk);
        chk("cancel_no_commit_lo", bus.lo, 32'h66);
        bus.cancel  = 1'b1;
        bus.start   = 1'b1;
        bus.op      = 3'd5;
        bus.rs_data = 32'h99;
        @(negedge clk);
        bus.cancel = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        chk("cancel_idle_blocks_mthi", bus.hi, 32'h55);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
